avmm_periph_arbiter: RTL
========================

Name: avmm_periph_arbiter

Overview:
- Two-master, one-slave Avalon-MM arbiter. It shares a single peripheral register port (UART/I2C/SPI peripheral CSR) between the NIOS master (m0) and the HPS lightweight-bridge master (m1).
- Grants are round-robin, with an optional lock that holds ownership across back-to-back transfers.
- A watchdog timeout terminates a stalled slave transfer with an error.
- Sits between the two masters and the peripheral slave inside the system fabric.

Parameters:
- ADDR_W, 8, slave word-address width
- DATA_W, 32, data width
- TIMEOUT, 255, max stalled cycles per transfer before forced termination; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m0_address  in  ADDR_W  master 0 address
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_lock  in  1  master 0 hold-grant request
- m0_readdata  out  DATA_W  master 0 read data
- m0_waitrequest  out  1  master 0 stall
- m0_error  out  1  master 0 timeout error, valid with waitrequest=0
- m1_* (8 ports)  as m0_*  master 1, identical set
- s_address  out  ADDR_W  slave address
- s_read  out  1  slave read
- s_write  out  1  slave write
- s_writedata  out  DATA_W  slave write data
- s_readdata  in  DATA_W  slave read data
- s_waitrequest  in  1  slave stall
- grant  out  2  one-hot current owner (status), 00 when idle

Behaviour:
- Request: req_n = mn_read | mn_write. Both asserted together is a protocol error; treated as a write.
- State: IDLE or BUSY. Registers: owner (1b), last_owner (1b), tmo_cnt (8b, sized to TIMEOUT).
- Reset values: state=IDLE, last_owner=1 (m0 wins the first tie), tmo_cnt=0, grant=00, s_read=s_write=0, s_address=s_writedata=0, m*_waitrequest=1, m*_readdata=0, m*_error=0. Reset overrides any in-flight transfer; the slave sees read/write drop in the next cycle.
- IDLE:
  - Slave strobes are 0; both waitrequests are 1.
  - One request pending: owner:=that master.
  - Both pending: owner:=~last_owner.
  - Next state is BUSY, tmo_cnt:=0. Latency from request to first slave strobe is 1 cycle.
- BUSY, slave side: s_* are driven combinationally from the owner's inputs.
- BUSY, owner side:
  - owner waitrequest = s_waitrequest.
  - owner readdata = s_readdata.
- BUSY, non-owner side: waitrequest=1, readdata=0, error=0.
- Completion: cycle in BUSY with owner req=1 and s_waitrequest=0.
  - last_owner:=owner, tmo_cnt:=0.
  - If owner lock=1 in that cycle: stay BUSY with the same owner.
  - Else: go to IDLE, giving one dead cycle before the next grant.
- Locked idle: BUSY with owner req=0.
  - lock=1: hold BUSY, strobes 0, tmo_cnt does not count.
  - lock=0: go to IDLE, last_owner:=owner.
- Watchdog (TIMEOUT>0):
  - tmo_cnt increments on each BUSY cycle with owner req=1 and s_waitrequest=1.
  - When tmo_cnt==TIMEOUT that cycle is the forced-termination cycle:
    - owner waitrequest=0, error=1, readdata=all-ones.
    - s_read and s_write are forced to 0.
    - lock is ignored; go to IDLE, last_owner:=owner, tmo_cnt:=0.
  - error is a single-cycle pulse.
- grant = one-hot(owner) in BUSY, 00 in IDLE.
- Fairness: a master requesting continuously without lock alternates with the other requester. Its worst-case wait is one transfer plus 2 cycles, or one transfer plus TIMEOUT+2 cycles.

Test Plan:
- m0 writes 0x12345678 to addr 0x04; slave waitrequest low immediately -> s_write at cycle t+1 with the same data/addr, m0_waitrequest low at t+1, grant 01→00.
- m0 and m1 both read continuously; slave returns 0xA5 with 2 wait cycles -> grants alternate m0, m1, m0, m1. Each read returns 0xA5 to the correct master only; the other master's waitrequest stays 1.
- m1 asserts lock over 3 back-to-back writes while m0 requests -> all 3 m1 writes complete before m0 is granted. m0 is granted in the cycle after m1 drops lock and the IDLE dead cycle.
- TIMEOUT=8; slave holds waitrequest high forever on an m0 read -> at the 9th stalled cycle: m0_waitrequest=0, m0_error=1, readdata=0xFFFFFFFF, s_read=0. The next cycle is IDLE and m1 is granted if pending.
- reset asserted mid-transfer while m1 is owner and locked -> next cycle state IDLE, grant=00, s_read=s_write=0. After release, a simultaneous request is granted to m0 first.
- TIMEOUT=0 with a 1000-cycle stall -> no error; the transfer completes normally when the slave releases waitrequest.

Source files
------------

// File: rtl/avmm_periph_arbiter.sv
// avmm_periph_arbiter: two-master round-robin Avalon-MM arbiter with lock and stall watchdog
module avmm_periph_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_lock,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    output logic              m0_error,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_lock,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic              m1_error,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_read,
    output logic              s_write,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    input  logic              s_waitrequest,
    output logic [1:0]        grant
);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state;
    logic            owner;
    logic            last_owner;
    logic [TW-1:0]   tmo_cnt;

    logic              req0, req1, busy;
    logic              o_read, o_write, o_lock, o_req;
    logic [ADDR_W-1:0] o_addr;
    logic [DATA_W-1:0] o_wdata;
    logic              tmo, done, sel0, sel1;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign busy    = state == BUSY;
    assign o_read  = owner ? m1_read : m0_read;
    assign o_write = owner ? m1_write : m0_write;
    assign o_lock  = owner ? m1_lock : m0_lock;
    assign o_addr  = owner ? m1_address : m0_address;
    assign o_wdata = owner ? m1_writedata : m0_writedata;
    assign o_req   = o_read | o_write;

    // forced termination wins over a same-cycle slave release
    assign tmo  = busy & o_req & (TIMEOUT != 0) & (tmo_cnt == TW'(TIMEOUT));
    assign done = busy & o_req & ~s_waitrequest & ~tmo;
    assign sel0 = busy & ~owner;
    assign sel1 = busy & owner;

    // read+write together is treated as a write
    assign s_read      = busy & ~tmo & o_read & ~o_write;
    assign s_write     = busy & ~tmo & o_write;
    assign s_address   = busy ? o_addr : '0;
    assign s_writedata = busy ? o_wdata : '0;

    assign m0_waitrequest = sel0 ? s_waitrequest & ~tmo : 1'b1;
    assign m1_waitrequest = sel1 ? s_waitrequest & ~tmo : 1'b1;
    assign m0_readdata    = sel0 ? (tmo ? '1 : s_readdata) : '0;
    assign m1_readdata    = sel1 ? (tmo ? '1 : s_readdata) : '0;
    assign m0_error       = sel0 & tmo;
    assign m1_error       = sel1 & tmo;
    assign grant          = {sel1, sel0};

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            tmo_cnt    <= '0;
        end else if (!busy) begin
            if (req0 | req1) begin
                state   <= BUSY;
                owner   <= (req0 & req1) ? ~last_owner : req1;
                tmo_cnt <= '0;
            end
        end else if (tmo) begin
            state      <= IDLE;
            last_owner <= owner;
            tmo_cnt    <= '0;
        end else if (done) begin
            last_owner <= owner;
            tmo_cnt    <= '0;
            if (!o_lock) state <= IDLE;
        end else if (!o_req) begin
            if (!o_lock) begin
                state      <= IDLE;
                last_owner <= owner;
            end
        end else if (TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
endmodule
